// File: rtl/mat_loader_pkg.sv
// Shared definitions for the matrix loader and the downstream multiply stage:
// default matrix geometry and the loader state enumeration.
package mat_loader_pkg;

    localparam int MAT_N     = 4;
    localparam int MAT_NBITS = 16;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        FULL   = 2'd2
    } ld_state_e;

    // Element index counter width for a frame of 2*N*N words.
    function automatic int idx_width(input int n);
        return $clog2(2 * n * n);
    endfunction

endpackage

// File: rtl/mat_loader.sv
// Streams a frame of 2*N*N words into two N x N operand matrices (A then B,
// row-major) and holds them with a valid/ready handshake for the multiply stage.
module mat_loader
    import mat_loader_pkg::*;
#(
    parameter int N     = MAT_N,
    parameter int NBITS = MAT_NBITS
) (
    input  logic                              CLK,
    input  logic                              RST_N,
    input  logic [NBITS-1:0]                  IN_DATA,
    input  logic                              IN_VALID,
    input  logic                              IN_LAST,
    output logic                              IN_READY,
    output logic [N-1:0][N-1:0][NBITS-1:0]    A,
    output logic [N-1:0][N-1:0][NBITS-1:0]    B,
    output logic                              OUT_VALID,
    input  logic                              OUT_READY,
    output logic                              ERR
);

    localparam int NN    = N * N;
    localparam int IDX_W = idx_width(N);
    localparam int EL_W  = $clog2(NN);

    localparam logic [IDX_W-1:0] IDX_A_END  = IDX_W'(NN - 1);
    localparam logic [IDX_W-1:0] IDX_B_END  = IDX_W'(2 * NN - 1);
    localparam logic [IDX_W-1:0] IDX_B_BASE = IDX_W'(NN);
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);

    ld_state_e                   state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic                        in_ready_q, in_ready_d;
    logic                        out_valid_q, out_valid_d;
    logic                        err_q, err_d;
    logic [NN-1:0][NBITS-1:0]    a_q, a_d;
    logic [NN-1:0][NBITS-1:0]    b_q, b_d;

    logic                        accept_s;
    logic [IDX_W-1:0]            b_off_s;
    logic [EL_W-1:0]             a_sel_s;
    logic [EL_W-1:0]             b_sel_s;

    assign accept_s = IN_VALID & in_ready_q;
    assign b_off_s  = idx_q - IDX_B_BASE;
    assign a_sel_s  = idx_q[EL_W-1:0];
    assign b_sel_s  = b_off_s[EL_W-1:0];

    // Next-state, element write and framing-error logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = err_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            LOAD_A: begin
                if (accept_s) begin
                    a_d[a_sel_s] = IN_DATA;
                    if (IN_LAST) begin
                        // Early LAST: drop the partial frame, stale elements stay.
                        err_d   = 1'b1;
                        idx_d   = '0;
                        state_d = LOAD_A;
                    end else if (idx_q == IDX_A_END) begin
                        idx_d   = idx_q + IDX_ONE;
                        state_d = LOAD_B;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            LOAD_B: begin
                if (accept_s) begin
                    b_d[b_sel_s] = IN_DATA;
                    if (idx_q == IDX_B_END) begin
                        // A missing LAST is flagged but the frame is still delivered.
                        err_d   = err_q | ~IN_LAST;
                        state_d = FULL;
                    end else if (IN_LAST) begin
                        err_d   = 1'b1;
                        idx_d   = '0;
                        state_d = LOAD_A;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            FULL: begin
                if (out_valid_q && OUT_READY) begin
                    idx_d   = '0;
                    state_d = LOAD_A;
                end else begin
                    state_d = FULL;
                end
            end
            default: begin
                idx_d   = '0;
                state_d = LOAD_A;
            end
        endcase
        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d == FULL);
    end

    // State, index, handshake flags and operand storage.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= LOAD_A;
            idx_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            a_q         <= a_d;
            b_q         <= b_d;
        end
    end

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = out_valid_q;
    assign ERR       = err_q;
    assign A         = a_q;
    assign B         = b_q;

endmodule

// File: tb/tb_mat_loader.sv
// Scoreboard bench for mat_loader: a word-level reference model queues expected
// frames, and a negedge monitor compares whenever OUT_VALID is presented.
module tb_mat_loader;

    localparam int N  = 4;
    localparam int NB = 16;
    localparam int NN = N * N;
    localparam int NW = 2 * NN;
    localparam int AW = NN * NB;

    typedef logic [AW-1:0] wide_t;

    typedef struct {
        wide_t a;
        wide_t b;
        logic  err;
    } exp_t;

    logic                        CLK = 1'b0;
    logic                        RST_N;
    logic [NB-1:0]               IN_DATA;
    logic                        IN_VALID;
    logic                        IN_LAST;
    logic                        IN_READY;
    logic [N-1:0][N-1:0][NB-1:0] A;
    logic [N-1:0][N-1:0][NB-1:0] B;
    logic                        OUT_VALID;
    logic                        OUT_READY;
    logic                        ERR;

    always #5 CLK = ~CLK;

    mat_loader #(.N(N), .NBITS(NB)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .IN_DATA  (IN_DATA),
        .IN_VALID (IN_VALID),
        .IN_LAST  (IN_LAST),
        .IN_READY (IN_READY),
        .A        (A),
        .B        (B),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY),
        .ERR      (ERR)
    );

    int            n_chk  = 0;
    int            n_fail = 0;
    exp_t          exp_q[$];
    logic [NB-1:0] cur_words[$];
    logic          model_err;
    logic [NB-1:0] fdata[NW];

    task automatic chk(input string name, input wide_t act, input wide_t expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Reference model: a frame is simply the list of accepted words.
    function automatic void model_accept(input logic [NB-1:0] d, input logic last);
        exp_t e;
        cur_words.push_back(d);
        if (cur_words.size() == NW) begin
            if (!last) model_err = 1'b1;
            for (int k = 0; k < NN; k++) begin
                e.a[k*NB +: NB] = cur_words[k];
                e.b[k*NB +: NB] = cur_words[NN + k];
            end
            e.err = model_err;
            exp_q.push_back(e);
            cur_words.delete();
        end else if (last) begin
            model_err = 1'b1;
            cur_words.delete();
        end
    endfunction

    function automatic void model_reset();
        cur_words.delete();
        exp_q.delete();
        model_err = 1'b0;
    endfunction

    // Monitor: compare each presented result against the scoreboard head.
    logic  prev_v = 1'b0;
    wide_t snap_a;
    wide_t snap_b;
    exp_t  mon_e;

    always @(negedge CLK) begin
        if (!RST_N) begin
            prev_v <= 1'b0;
        end else if (OUT_VALID) begin
            chk("in_ready_low_when_full", wide_t'(IN_READY), wide_t'(1'b0));
            if (!prev_v) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_out_valid: got a result, expected none");
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("frame_a", wide_t'(A), mon_e.a);
                    chk("frame_b", wide_t'(B), mon_e.b);
                    chk("frame_err", wide_t'(ERR), wide_t'(mon_e.err));
                end
            end else begin
                chk("a_stable", wide_t'(A), snap_a);
                chk("b_stable", wide_t'(B), snap_b);
            end
            snap_a <= wide_t'(A);
            snap_b <= wide_t'(B);
            prev_v <= 1'b1;
        end else begin
            prev_v <= 1'b0;
        end
    end

    task automatic send_word(input logic [NB-1:0] d, input logic last, input int gap);
        int   t;
        logic acc;
        for (int g = 0; g < gap; g++) begin
            IN_VALID = 1'b0;
            IN_DATA  = 16'($urandom);
            IN_LAST  = 1'($urandom);
            @(posedge CLK);
            #1;
        end
        IN_VALID = 1'b1;
        IN_DATA  = d;
        IN_LAST  = last;
        t        = 0;
        acc      = 1'b0;
        forever begin
            acc = IN_READY;
            @(posedge CLK);
            #1;
            if (acc) break;
            t++;
            if (t > 200) begin
                n_chk++;
                n_fail++;
                $display("FAIL accept_timeout: got no acceptance, expected IN_READY");
                break;
            end
        end
        if (acc) model_accept(d, last);
        IN_VALID = 1'b0;
        IN_LAST  = 1'b0;
    endtask

    // gap_mode: 0 back-to-back, 1 IN_VALID toggling, 2 random gaps.
    task automatic send_frame(input int nw, input int last_at, input int gap_mode);
        int gap;
        for (int i = 0; i < nw; i++) begin
            gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(2, 0));
            send_word(fdata[i], (i == last_at), gap);
        end
    endtask

    task automatic wait_idle();
        OUT_READY = 1'b1;
        for (int t = 0; t < 100; t++) begin
            if (!OUT_VALID) break;
            @(posedge CLK);
            #1;
        end
        chk("drain", wide_t'(OUT_VALID), wide_t'(1'b0));
    endtask

    task automatic fill_random();
        for (int i = 0; i < NW; i++) fdata[i] = 16'($urandom);
    endtask

    task automatic fill_count();
        for (int i = 0; i < NW; i++) fdata[i] = 16'(i + 1);
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        #1;
        model_reset();
        chk("rst_in_ready", wide_t'(IN_READY), wide_t'(1'b0));
        chk("rst_out_valid", wide_t'(OUT_VALID), wide_t'(1'b0));
        chk("rst_err", wide_t'(ERR), wide_t'(1'b0));
        chk("rst_a", wide_t'(A), wide_t'(0));
        chk("rst_b", wide_t'(B), wide_t'(0));
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        chk("in_ready_after_rst", wide_t'(IN_READY), wide_t'(1'b1));
    endtask

    initial begin
        int kind;
        int pos;
        RST_N     = 1'b1;
        IN_VALID  = 1'b0;
        IN_LAST   = 1'b0;
        IN_DATA   = '0;
        OUT_READY = 1'b1;
        model_err = 1'b0;
        #1;
        do_reset();

        // Basic frame 1..32, single-cycle OUT_VALID.
        fill_count();
        send_frame(NW, NW - 1, 0);
        chk("basic_ov", wide_t'(OUT_VALID), wide_t'(1'b1));
        chk("basic_ir", wide_t'(IN_READY), wide_t'(1'b0));
        chk("basic_a00", wide_t'(A[0][0]), wide_t'(16'd1));
        chk("basic_a33", wide_t'(A[3][3]), wide_t'(16'd16));
        chk("basic_b00", wide_t'(B[0][0]), wide_t'(16'd17));
        chk("basic_b33", wide_t'(B[3][3]), wide_t'(16'd32));
        chk("basic_err", wide_t'(ERR), wide_t'(1'b0));
        @(posedge CLK);
        #1;
        chk("basic_ov_drop", wide_t'(OUT_VALID), wide_t'(1'b0));
        chk("basic_ir_rise", wide_t'(IN_READY), wide_t'(1'b1));

        // Backpressure: result held for 10 cycles.
        fill_random();
        OUT_READY = 1'b0;
        send_frame(NW, NW - 1, 0);
        repeat (10) begin
            @(posedge CLK);
            #1;
            chk("bp_ov_held", wide_t'(OUT_VALID), wide_t'(1'b1));
            chk("bp_ir_low", wide_t'(IN_READY), wide_t'(1'b0));
        end
        OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        chk("bp_ov_drop", wide_t'(OUT_VALID), wide_t'(1'b0));
        chk("bp_ir_rise", wide_t'(IN_READY), wide_t'(1'b1));

        // Gapped input with IN_VALID toggling every cycle.
        fill_count();
        send_frame(NW, NW - 1, 1);
        chk("gap_ov", wide_t'(OUT_VALID), wide_t'(1'b1));
        chk("gap_a33", wide_t'(A[3][3]), wide_t'(16'd16));
        chk("gap_b33", wide_t'(B[3][3]), wide_t'(16'd32));
        wait_idle();

        // Early LAST on word 5, then a good frame.
        fill_random();
        send_frame(5, 4, 0);
        chk("early_err", wide_t'(ERR), wide_t'(1'b1));
        chk("early_no_ov", wide_t'(OUT_VALID), wide_t'(1'b0));
        fill_random();
        send_frame(NW, NW - 1, 0);
        chk("early_next_ov", wide_t'(OUT_VALID), wide_t'(1'b1));
        wait_idle();

        // Reset after word 20, then a fresh frame.
        fill_random();
        send_frame(20, -1, 0);
        do_reset();
        fill_random();
        send_frame(NW, NW - 1, 0);
        chk("post_rst_ov", wide_t'(OUT_VALID), wide_t'(1'b1));
        chk("post_rst_err", wide_t'(ERR), wide_t'(1'b0));
        wait_idle();

        // Missing LAST: frame still delivered, ERR raised.
        fill_random();
        send_frame(NW, -1, 0);
        chk("nolast_ov", wide_t'(OUT_VALID), wide_t'(1'b1));
        chk("nolast_err", wide_t'(ERR), wide_t'(1'b1));
        wait_idle();

        // Randomised frames with gaps, backpressure and framing errors.
        do_reset();
        for (int f = 0; f < 10; f++) begin
            fill_random();
            OUT_READY = 1'($urandom);
            kind = int'($urandom_range(5, 0));
            if (kind == 0) begin
                pos = int'($urandom_range(NW - 2, 0));
                send_frame(pos + 1, pos, 2);
            end else begin
                send_frame(NW, (kind == 1) ? -1 : NW - 1, 2);
                repeat ($urandom_range(4, 0)) begin
                    @(posedge CLK);
                    #1;
                end
                wait_idle();
            end
        end

        chk("queue_drained", wide_t'(exp_q.size()), wide_t'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mat_loader.md
MAT_LOADER -- requirements
Module: mat_loader

Interface
REQ-001 SHALL have parameter N, default 4, matrix dimension (square N x N).
REQ-002 SHALL have parameter NBITS, default 16, element width in bits.
REQ-003 SHALL have port CLK  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port RST_N  input  1  asynchronous active-low reset.
REQ-005 SHALL have port IN_DATA  input  NBITS  unsigned element word.
REQ-006 SHALL have port IN_VALID  input  1  IN_DATA holds a valid word.
REQ-007 SHALL have port IN_LAST  input  1  word is the final word of a frame.
REQ-008 SHALL have port IN_READY  output  1  block accepts a word this cycle.
REQ-009 SHALL have port A  output  NBITS x [N][N]  assembled left operand.
REQ-010 SHALL have port B  output  NBITS x [N][N]  assembled right operand.
REQ-011 SHALL have port OUT_VALID  output  1  A and B are complete and stable.
REQ-012 SHALL have port OUT_READY  input  1  downstream multiply stage takes A/B this cycle.
REQ-013 SHALL have port ERR  output  1  sticky frame-framing error flag.

Function
REQ-014 SHALL accept a word on a rising edge where IN_VALID and IN_READY are both 1, at most one word per cycle.
REQ-015 SHALL treat a frame as 2*N*N words: first N*N fill A row-major (A[0][0], A[0][1], ...), next N*N fill B row-major; element index counter width clog2(2*N*N) (5 bits at N=4).
REQ-016 SHALL implement states LOAD_A, LOAD_B, FULL: LOAD_A->LOAD_B on acceptance of index N*N-1; LOAD_B->FULL on acceptance of index 2*N*N-1; FULL->LOAD_A on the edge where OUT_VALID and OUT_READY are both 1.
REQ-017 SHALL drive IN_READY and OUT_VALID as registered outputs: IN_READY=1 in LOAD_A/LOAD_B, 0 in FULL; OUT_VALID=1 only in FULL.
REQ-018 SHALL assert OUT_VALID in the cycle after the final word is accepted, with IN_READY deasserted in that same cycle.
REQ-019 SHALL hold A and B unchanged while OUT_VALID=1 and until the next frame overwrites individual elements.
REQ-020 SHALL, when OUT_VALID and OUT_READY are both 1, reset the index to 0, drop OUT_VALID and raise IN_READY in the next cycle (33 cycles minimum per N=4 frame).
REQ-021 SHALL keep OUT_VALID asserted indefinitely while OUT_READY=0 (no timeout, no data loss).
REQ-022 SHALL, on an accepted word with IN_LAST=1 at index below 2*N*N-1, set ERR, discard the partial frame, return to LOAD_A with index 0; already-written elements keep stale values.
REQ-023 SHALL, on the final-index word accepted with IN_LAST=0, set ERR but still complete the frame and enter FULL.
REQ-024 SHALL clear ERR only by reset.
REQ-025 SHALL ignore IN_DATA and IN_LAST when no word is accepted; OUT_READY is ignored outside FULL.

Reset
REQ-026 SHALL, while RST_N=0, immediately force state LOAD_A, index 0, IN_READY=0, OUT_VALID=0, ERR=0, all A and B elements 0.
REQ-027 SHALL raise IN_READY on the first rising edge after RST_N deasserts.
REQ-028 SHALL abandon any in-progress frame or pending output on reset, with no partial delivery afterwards.

Structure
REQ-029 SHALL take default N, NBITS and the state enumeration from a shared package, so the same package also parameterises the matrix-multiply stage.
REQ-030 SHALL be a single module with no sub-module; the parent wires A/B directly to the matrix-multiply stage and uses OUT_VALID/OUT_READY to sample its result.

Verification
REQ-031 Bench SHALL check a basic frame: stream 1..16 then 17..32, LAST on word 32, OUT_READY=1 -> A[0][0]=1, A[3][3]=16, B[0][0]=17, B[3][3]=32, OUT_VALID for exactly 1 cycle, ERR=0.
REQ-032 Bench SHALL check backpressure: OUT_READY=0 for 10 cycles after a full frame -> OUT_VALID held, IN_READY=0, A/B stable; OUT_READY=1 -> IN_READY=1 next cycle.
REQ-033 Bench SHALL check an early LAST: LAST on word 5 -> ERR=1, next 32 words with LAST on word 32 form a correct frame.
REQ-034 Bench SHALL check a missing LAST: 32 words with LAST=0 -> ERR=1 and OUT_VALID=1 with correct A/B.
REQ-035 Bench SHALL check reset mid-frame: RST_N low after word 20 -> all outputs 0 immediately; a fresh 32-word frame then loads correctly.
REQ-036 Bench SHALL check gapped input: IN_VALID toggling 1/0 every cycle -> same result as scenario REQ-031, with OUT_VALID following acceptance of word 32.
